// File: rtl/oclib_pkg.sv
// oclib_pkg: shared constants and types for the oclib CSR infrastructure.
//   BcBlockIdAny       - wildcard block ID; a block configured with it answers every block ID
//   BcSpaceIdAny       - wildcard space ID; a target configured with it accepts every space
//   csr_demux_state_e  - state encoding of the registered CSR select/demux
package oclib_pkg;

  localparam logic [31:0] BcBlockIdAny = 32'hFFFF_FFFF;
  localparam logic [3:0]  BcSpaceIdAny = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } csr_demux_state_e;

endpackage

// File: rtl/oclib_csr_space_match.sv
// oclib_csr_space_match: combinational priority matcher of a CSR space ID
// against a packed table of per-target space IDs. The lowest-indexed entry
// that equals the space, or that holds the wildcard BcSpaceIdAny, wins.
// Ports:
//   space  in   4         space ID to look up
//   hit    out  1         at least one entry matched
//   index  out  IdxWidth  lowest matching entry (0 when no hit)
module oclib_csr_space_match
  import oclib_pkg::*;
#(
  parameter int                       NumTargets = 4,
  parameter int                       IdxWidth   = 2,
  parameter logic [NumTargets*4-1:0]  SpaceIds   = {4'd3, 4'd2, 4'd1, 4'd0}
) (
  input  logic [3:0]          space,
  output logic                hit,
  output logic [IdxWidth-1:0] index
);

  logic [NumTargets-1:0] match_s;

  // Per-entry compare against the looked-up space or the wildcard.
  always_comb begin
    match_s = {NumTargets{1'b0}};
    for (int i = 0; i < NumTargets; i++) begin
      match_s[i] = (SpaceIds[i*4 +: 4] == space) || (SpaceIds[i*4 +: 4] == BcSpaceIdAny);
    end
  end

  // Priority encode: scanning downward lets the lowest matching index overwrite the rest.
  always_comb begin
    index = {IdxWidth{1'b0}};
    for (int i = NumTargets - 1; i >= 0; i--) begin
      index = match_s[i] ? IdxWidth'(i) : index;
    end
    hit = |match_s;
  end

endmodule

// File: rtl/oclib_csr_select_demux.sv
// oclib_csr_select_demux: registered CSR entry point. Accepts one request at a
// time, qualifies it against this block's ID, routes it to the lowest-indexed
// target whose space ID matches, and returns exactly one upstream response:
// target data, an unmapped-space error, or a timeout error.
// Ports:
//   clock, reset                       clock and synchronous active-high reset
//   csrReqValid/Ready/Block/Space/...  upstream request (Ready high only when idle)
//   csrRespValid/Ready/Rdata/Error/... upstream response (Rdata is 0 on any error)
//   targetReq*                         one-hot valid plus shared registered payload
//   targetResp*                        per-target response valid/data/error
//   dropCount                          saturating count of block-mismatch drops
//   busy                               a request is in flight
module oclib_csr_select_demux
  import oclib_pkg::*;
#(
  parameter int                      NumTargets    = 4,
  parameter logic [31:0]             AnswerToBlock = oclib_pkg::BcBlockIdAny,
  parameter logic [NumTargets*4-1:0] SpaceIds      = {4'd3, 4'd2, 4'd1, 4'd0},
  parameter int                      AddressWidth  = 32,
  parameter int                      DataWidth     = 32,
  parameter int                      TimeoutCycles = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             csrReqValid,
  output logic                             csrReqReady,
  input  logic [31:0]                      csrReqBlock,
  input  logic [3:0]                       csrReqSpace,
  input  logic [AddressWidth-1:0]          csrReqAddress,
  input  logic                             csrReqWrite,
  input  logic [DataWidth-1:0]             csrReqWdata,
  output logic                             csrRespValid,
  input  logic                             csrRespReady,
  output logic [DataWidth-1:0]             csrRespRdata,
  output logic                             csrRespError,
  output logic                             csrRespTimeout,
  output logic [NumTargets-1:0]            targetReqValid,
  input  logic [NumTargets-1:0]            targetReqReady,
  output logic [AddressWidth-1:0]          targetReqAddress,
  output logic                             targetReqWrite,
  output logic [DataWidth-1:0]             targetReqWdata,
  input  logic [NumTargets-1:0]            targetRespValid,
  input  logic [NumTargets*DataWidth-1:0]  targetRespRdata,
  input  logic [NumTargets-1:0]            targetRespError,
  output logic [7:0]                       dropCount,
  output logic                             busy
);

  localparam int IdxWidth = (NumTargets > 1) ? $clog2(NumTargets) : 1;
  localparam int CntWidth = $clog2(TimeoutCycles) + 1;
  localparam logic [CntWidth-1:0] TimeoutLimit = CntWidth'(TimeoutCycles - 1);

  csr_demux_state_e state_r, state_n;

  logic                    req_ready_r, req_ready_n;
  logic                    resp_valid_r, resp_valid_n;
  logic [DataWidth-1:0]    resp_rdata_r, resp_rdata_n;
  logic                    resp_error_r, resp_error_n;
  logic                    resp_timeout_r, resp_timeout_n;
  logic [NumTargets-1:0]   tgt_valid_r, tgt_valid_n;
  logic                    busy_r, busy_n;
  logic [IdxWidth-1:0]     idx_r, idx_n;
  logic [AddressWidth-1:0] addr_r;
  logic                    write_r;
  logic [DataWidth-1:0]    wdata_r;
  logic [7:0]              drop_r;
  logic [CntWidth-1:0]     cnt_r, cnt_n;

  logic                    block_hit_s;
  logic                    space_hit_s;
  logic [IdxWidth-1:0]     space_idx_s;
  logic                    capture_s;
  logic                    fwd_hs_s;
  logic                    resp_hs_s;
  logic                    timeout_s;
  logic [DataWidth-1:0]    lane_rdata_s;

  oclib_csr_space_match #(
    .NumTargets (NumTargets),
    .IdxWidth   (IdxWidth),
    .SpaceIds   (SpaceIds)
  ) u_space_match (
    .space (csrReqSpace),
    .hit   (space_hit_s),
    .index (space_idx_s)
  );

  // Request qualification, handshakes with the selected target, and timeout detection.
  always_comb begin
    block_hit_s  = (AnswerToBlock == BcBlockIdAny) || (csrReqBlock == AnswerToBlock);
    capture_s    = (state_r == IDLE) && csrReqValid;
    fwd_hs_s     = targetReqReady[idx_r];
    resp_hs_s    = targetRespValid[idx_r];
    timeout_s    = (cnt_r >= TimeoutLimit);
    lane_rdata_s = targetRespRdata[idx_r*DataWidth +: DataWidth];
  end

  // Next-state logic; a handshake in the timeout cycle takes priority over the timeout.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (csrReqValid && block_hit_s) begin
          state_n = space_hit_s ? FORWARD : RESPOND;
        end else begin
          state_n = IDLE;
        end
      end
      FORWARD: begin
        if (fwd_hs_s) begin
          state_n = WAIT;
        end else if (timeout_s) begin
          state_n = RESPOND;
        end else begin
          state_n = FORWARD;
        end
      end
      WAIT: begin
        if (resp_hs_s || timeout_s) begin
          state_n = RESPOND;
        end else begin
          state_n = WAIT;
        end
      end
      RESPOND: begin
        if (csrRespReady) begin
          state_n = IDLE;
        end else begin
          state_n = RESPOND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    idx_n          = capture_s ? space_idx_s : idx_r;
    req_ready_n    = (state_n == IDLE);
    resp_valid_n   = (state_n == RESPOND);
    busy_n         = (state_n != IDLE);
    tgt_valid_n    = {NumTargets{1'b0}};
    resp_rdata_n   = resp_rdata_r;
    resp_error_n   = resp_error_r;
    resp_timeout_n = resp_timeout_r;
    for (int i = 0; i < NumTargets; i++) begin
      tgt_valid_n[i] = (state_n == FORWARD) && (idx_n == IdxWidth'(i));
    end
    case (state_r)
      IDLE: begin
        // Only an unmapped space reaches RESPOND straight from IDLE.
        if (state_n == RESPOND) begin
          resp_rdata_n   = {DataWidth{1'b0}};
          resp_error_n   = 1'b1;
          resp_timeout_n = 1'b0;
        end else begin
          resp_rdata_n   = resp_rdata_r;
          resp_error_n   = resp_error_r;
          resp_timeout_n = resp_timeout_r;
        end
      end
      FORWARD: begin
        if (state_n == RESPOND) begin
          resp_rdata_n   = {DataWidth{1'b0}};
          resp_error_n   = 1'b1;
          resp_timeout_n = 1'b1;
        end else begin
          resp_rdata_n   = resp_rdata_r;
          resp_error_n   = resp_error_r;
          resp_timeout_n = resp_timeout_r;
        end
      end
      WAIT: begin
        if (resp_hs_s) begin
          // Read data is forced to zero whenever the target flags an error.
          resp_rdata_n   = targetRespError[idx_r] ? {DataWidth{1'b0}} : lane_rdata_s;
          resp_error_n   = targetRespError[idx_r];
          resp_timeout_n = 1'b0;
        end else if (state_n == RESPOND) begin
          resp_rdata_n   = {DataWidth{1'b0}};
          resp_error_n   = 1'b1;
          resp_timeout_n = 1'b1;
        end else begin
          resp_rdata_n   = resp_rdata_r;
          resp_error_n   = resp_error_r;
          resp_timeout_n = resp_timeout_r;
        end
      end
      RESPOND: begin
        // Response fields return to zero once the response has been taken.
        if (state_n == IDLE) begin
          resp_rdata_n   = {DataWidth{1'b0}};
          resp_error_n   = 1'b0;
          resp_timeout_n = 1'b0;
        end else begin
          resp_rdata_n   = resp_rdata_r;
          resp_error_n   = resp_error_r;
          resp_timeout_n = resp_timeout_r;
        end
      end
      default: begin
        resp_rdata_n   = {DataWidth{1'b0}};
        resp_error_n   = 1'b0;
        resp_timeout_n = 1'b0;
      end
    endcase
  end

  // Timeout counter: zero outside FORWARD/WAIT (so it is zero on entry), saturating inside.
  always_comb begin
    if (((state_r == FORWARD) || (state_r == WAIT)) &&
        ((state_n == FORWARD) || (state_n == WAIT))) begin
      cnt_n = timeout_s ? cnt_r : (cnt_r + {{(CntWidth-1){1'b0}}, 1'b1});
    end else begin
      cnt_n = {CntWidth{1'b0}};
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      req_ready_r    <= 1'b1;
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= {DataWidth{1'b0}};
      resp_error_r   <= 1'b0;
      resp_timeout_r <= 1'b0;
      tgt_valid_r    <= {NumTargets{1'b0}};
      busy_r         <= 1'b0;
      cnt_r          <= {CntWidth{1'b0}};
    end else begin
      state_r        <= state_n;
      req_ready_r    <= req_ready_n;
      resp_valid_r   <= resp_valid_n;
      resp_rdata_r   <= resp_rdata_n;
      resp_error_r   <= resp_error_n;
      resp_timeout_r <= resp_timeout_n;
      tgt_valid_r    <= tgt_valid_n;
      busy_r         <= busy_n;
      cnt_r          <= cnt_n;
    end
  end

  // Request payload capture, target index, and the block-mismatch drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_r   <= {IdxWidth{1'b0}};
      addr_r  <= {AddressWidth{1'b0}};
      write_r <= 1'b0;
      wdata_r <= {DataWidth{1'b0}};
      drop_r  <= 8'd0;
    end else if (capture_s) begin
      idx_r   <= idx_n;
      addr_r  <= csrReqAddress;
      write_r <= csrReqWrite;
      wdata_r <= csrReqWdata;
      if (!block_hit_s && (drop_r != 8'd255)) begin
        drop_r <= drop_r + 8'd1;
      end else begin
        drop_r <= drop_r;
      end
    end else begin
      idx_r   <= idx_r;
      addr_r  <= addr_r;
      write_r <= write_r;
      wdata_r <= wdata_r;
      drop_r  <= drop_r;
    end
  end

  assign csrReqReady      = req_ready_r;
  assign csrRespValid     = resp_valid_r;
  assign csrRespRdata     = resp_rdata_r;
  assign csrRespError     = resp_error_r;
  assign csrRespTimeout   = resp_timeout_r;
  assign targetReqValid   = tgt_valid_r;
  assign targetReqAddress = addr_r;
  assign targetReqWrite   = write_r;
  assign targetReqWdata   = wdata_r;
  assign dropCount        = drop_r;
  assign busy             = busy_r;

endmodule
